// File: rtl/ibex_mult_pext_seq.sv
// rtl/ibex_mult_pext_seq.sv - sequenced P-extension multiply/accumulate datapath
module ibex_mult_pext_seq #(
   parameter bit ACC_SAT = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        kill_i,
   input  logic [1:0]  mult_mode_i,
   input  logic [1:0]  cycle_count_i,
   input  logic [1:0]  accum_sub_i,
   input  logic        dsum_mult_i,
   input  logic        crossed_i,
   input  logic        accum_i,
   input  logic        signed_a_i,
   input  logic        signed_b_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic [31:0] op_c_i,
   output logic        ready_o,
   output logic        valid_o,
   output logic [31:0] result_o,
   output logic        sat_o
);

   typedef enum logic [1:0] {S_IDLE, S_HI, S_ACC} state_e;

   localparam logic [1:0] M8X8   = 2'd0;
   localparam logic [1:0] M16X16 = 2'd1;
   localparam logic [1:0] M32X16 = 2'd2;
   localparam logic [1:0] M32X32 = 2'd3;

   state_e      r_state, w_next;
   logic [1:0]  r_mode, r_cc, r_sub;
   logic        r_dsum, r_accum;
   logic [31:0] r_op_c;
   logic [63:0] r_prod;
   logic        r_valid, r_sat;
   logic [31:0] r_result;

   logic        w_capture, w_finish;
   logic [31:0] w_bx;
   logic [63:0] w_ma, w_mb, w_prod;
   logic [31:0] w_p1, w_p0, w_sum8;

   logic [1:0]  w_s_mode, w_s_cc, w_s_sub;
   logic        w_s_dsum, w_s_accum;
   logic [31:0] w_s_c;
   logic [63:0] w_s_prod;
   logic [33:0] w_s34, w_sum34;
   logic [32:0] w_rs;
   logic [31:0] w_res;
   logic        w_sat;

   function automatic logic [31:0] ext8(input logic [7:0] v, input logic s);
      return {{24{s & v[7]}}, v};
   endfunction

   function automatic logic [31:0] ext16(input logic [15:0] v, input logic s);
      return {{16{s & v[15]}}, v};
   endfunction

   function automatic logic [33:0] sx34(input logic [31:0] v);
      return {{2{v[31]}}, v};
   endfunction

   // Clamp a 34-bit signed sum to 32 bits; bit 32 of the return flags a clamp.
   function automatic logic [32:0] sat32(input logic [33:0] v);
      if (!v[33] && (v[32:31] != 2'b00)) return {1'b1, 32'h7FFF_FFFF};
      else if (v[33] && (v[32:31] != 2'b11)) return {1'b1, 32'h8000_0000};
      else return {1'b0, v[31:0]};
   endfunction

   assign ready_o  = (r_state == S_IDLE);
   assign valid_o  = r_valid;
   assign result_o = r_result;
   assign sat_o    = r_sat;

   // Product of the live inputs, formed in the start cycle and registered.
   // 16x16 keeps {p1,p0}; 8x8 keeps the four-lane sum in the low word.
   always_comb begin
      w_bx   = crossed_i ? {op_b_i[15:0], op_b_i[31:16]} : op_b_i;
      w_ma   = {{32{signed_a_i & op_a_i[31]}}, op_a_i};
      w_mb   = {{32{signed_b_i & w_bx[31]}}, w_bx};
      w_p1   = ext16(op_a_i[31:16], signed_a_i) * ext16(w_bx[31:16], signed_b_i);
      w_p0   = ext16(op_a_i[15:0], signed_a_i) * ext16(w_bx[15:0], signed_b_i);
      w_sum8 = '0;
      for (int i = 0; i < 4; i++) begin
         w_sum8 = w_sum8 + ext8(op_a_i[8*i +: 8], signed_a_i) * ext8(op_b_i[8*i +: 8], signed_b_i);
      end
      if (mult_mode_i == M32X16) begin
         w_ma = {{32{op_a_i[31]}}, op_a_i};
         w_mb = {{48{w_bx[15]}}, w_bx[15:0]};
      end
      case (mult_mode_i)
         M8X8:    w_prod = {32'h0, w_sum8};
         M16X16:  w_prod = {w_p1, w_p0};
         default: w_prod = w_ma * w_mb;
      endcase
   end

   // Finishing in IDLE means a single-cycle op: take the live inputs, otherwise the captured ones.
   always_comb begin
      if (r_state == S_IDLE) begin
         w_s_mode = mult_mode_i;  w_s_cc = cycle_count_i; w_s_sub = accum_sub_i;
         w_s_dsum = dsum_mult_i;  w_s_accum = accum_i;    w_s_c = op_c_i;
         w_s_prod = w_prod;
      end else begin
         w_s_mode = r_mode;  w_s_cc = r_cc;       w_s_sub = r_sub;
         w_s_dsum = r_dsum;  w_s_accum = r_accum; w_s_c = r_op_c;
         w_s_prod = r_prod;
      end
   end

   // Final result and saturation from the selected product and accumulator.
   always_comb begin
      w_res   = '0;
      w_sat   = 1'b0;
      w_s34   = '0;
      w_sum34 = '0;
      w_rs    = '0;
      case (w_s_mode)
         M32X32: begin
            case (w_s_cc)
               2'b00: w_res = w_s_prod[31:0];
               2'b01: w_res = w_s_prod[63:32];
               2'b10: w_res = w_s_sub[1] ? (w_s_c - w_s_prod[31:0]) : (w_s_c + w_s_prod[31:0]);
               default: begin
                  w_sum34 = w_s_sub[1] ? (sx34(w_s_c) - sx34(w_s_prod[63:32]))
                                       : (sx34(w_s_c) + sx34(w_s_prod[63:32]));
                  if (ACC_SAT) begin
                     w_rs  = sat32(w_sum34);
                     w_sat = w_rs[32];
                     w_res = w_rs[31:0];
                  end else begin
                     w_res = w_sum34[31:0];
                  end
               end
            endcase
         end
         M32X16: w_res = w_s_prod[47:16];
         M16X16: begin
            if (w_s_dsum)
               w_s34 = w_s_sub[0] ? (sx34(w_s_prod[63:32]) - sx34(w_s_prod[31:0]))
                                  : (sx34(w_s_prod[63:32]) + sx34(w_s_prod[31:0]));
            else
               w_s34 = sx34(w_s_prod[31:0]);
            if (w_s_accum || w_s_dsum) begin
               w_sum34 = w_s_sub[1] ? (sx34(w_s_c) - w_s34) : (sx34(w_s_c) + w_s34);
               w_rs    = sat32(w_sum34);
               w_sat   = w_rs[32];
               w_res   = w_rs[31:0];
            end else begin
               w_res = w_s_prod[31:0];
            end
         end
         default: w_res = w_s_c + w_s_prod[31:0];
      endcase
   end

   // Next-state and control strobes; kill always wins and returns to IDLE.
   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_finish  = 1'b0;
      if (kill_i) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  w_capture = 1'b1;
                  case (cycle_count_i)
                     2'b00:   w_finish = 1'b1;
                     2'b10:   w_next = S_ACC;
                     default: w_next = S_HI;
                  endcase
               end
            end
            S_HI: begin
               if (r_cc == 2'b11) begin
                  w_next = S_ACC;
               end else begin
                  w_next   = S_IDLE;
                  w_finish = 1'b1;
               end
            end
            default: begin
               w_next   = S_IDLE;
               w_finish = 1'b1;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Operand, flag and product capture on an accepted start.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mode <= '0; r_cc <= '0; r_sub <= '0; r_dsum <= 1'b0; r_accum <= 1'b0;
         r_op_c <= '0; r_prod <= '0;
      end else if (w_capture) begin
         r_mode <= mult_mode_i; r_cc <= cycle_count_i; r_sub <= accum_sub_i;
         r_dsum <= dsum_mult_i; r_accum <= accum_i; r_op_c <= op_c_i; r_prod <= w_prod;
      end
   end

   // Result strobe; result and saturation hold between strobes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= 1'b0; r_result <= '0; r_sat <= 1'b0;
      end else begin
         r_valid <= w_finish;
         if (w_finish) begin
            r_result <= w_res;
            r_sat    <= w_sat;
         end
      end
   end

endmodule
